// File: rtl/stream_pkg.sv
// Shared stream-block definitions: FSM state encoding and default widths.
// Reused by stream_burst_tx and future stream_burst_rx / checker blocks.
package stream_pkg;

  localparam int unsigned STREAM_DW    = 16;
  localparam int unsigned STREAM_LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_t;

endpackage

// File: rtl/stream_burst_tx.sv
// Valid/ready burst transmitter: accepts a (start, len, step) descriptor and
// emits len+1 words start, start+step, ... on a valid/ready output stream.
// Optional feature macro STREAM_TX_CSUM_EN: append one checksum word (sum of
// all data words, mod 2^DW) carrying out_last after the final data word.
module stream_burst_tx
  import stream_pkg::*;
#(
  parameter int unsigned DW    = STREAM_DW,
  parameter int unsigned LEN_W = STREAM_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [DW-1:0]    cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [DW-1:0]    cmd_step,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [DW-1:0]    step, step_nxt;
  logic [DW-1:0]    data_nxt;
  logic             vld_nxt, last_nxt;
  logic             beat;
`ifdef STREAM_TX_CSUM_EN
  logic [DW-1:0]    sum, sum_nxt;
`endif

  assign beat = out_vld && out_rdy;

  // Next-state, datapath and command-ready decode.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    step_nxt      = step;
    data_nxt      = out_data;
    vld_nxt       = out_vld;
    last_nxt      = out_last;
    cmd_rdy       = 1'b0;
`ifdef STREAM_TX_CSUM_EN
    sum_nxt       = sum;
`endif
    case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_vld) begin
          state_nxt     = SEND;
          remaining_nxt = cmd_len;
          step_nxt      = cmd_step;
          data_nxt      = cmd_start;
          vld_nxt       = 1'b1;
`ifdef STREAM_TX_CSUM_EN
          // The checksum word, not the final data word, closes the burst.
          last_nxt      = 1'b0;
          sum_nxt       = '0;
`else
          last_nxt      = (cmd_len == '0);
`endif
        end
      end
      SEND: begin
        if (beat) begin
`ifdef STREAM_TX_CSUM_EN
          sum_nxt = sum + out_data;
`endif
          if (remaining != '0) begin
            remaining_nxt = remaining - LEN_W'(1);
            data_nxt      = out_data + step;
`ifdef STREAM_TX_CSUM_EN
            last_nxt      = 1'b0;
`else
            last_nxt      = (remaining == LEN_W'(1));
`endif
          end else begin
`ifdef STREAM_TX_CSUM_EN
            state_nxt = CSUM;
            data_nxt  = sum + out_data;
            last_nxt  = 1'b1;
`else
            state_nxt = IDLE;
            data_nxt  = '0;
            vld_nxt   = 1'b0;
            last_nxt  = 1'b0;
`endif
          end
        end
      end
`ifdef STREAM_TX_CSUM_EN
      CSUM: begin
        if (beat) begin
          state_nxt = IDLE;
          data_nxt  = '0;
          vld_nxt   = 1'b0;
          last_nxt  = 1'b0;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        data_nxt  = '0;
        vld_nxt   = 1'b0;
        last_nxt  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset discards any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      step      <= '0;
      out_data  <= '0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
`ifdef STREAM_TX_CSUM_EN
      sum       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      step      <= step_nxt;
      out_data  <= data_nxt;
      out_vld   <= vld_nxt;
      out_last  <= last_nxt;
      busy      <= (state_nxt != IDLE);
`ifdef STREAM_TX_CSUM_EN
      sum       <= sum_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_stream_burst_tx.sv
// Directed self-checking bench for stream_burst_tx (default and
// STREAM_TX_CSUM_EN builds). Inputs driven and outputs sampled on negedge.
module tb_stream_burst_tx;

  localparam int unsigned DW    = 16;
  localparam int unsigned LEN_W = 8;

  logic             clk;
  logic             rst;
  logic             cmd_vld;
  logic             cmd_rdy;
  logic [DW-1:0]    cmd_start;
  logic [LEN_W-1:0] cmd_len;
  logic [DW-1:0]    cmd_step;
  logic             out_vld;
  logic             out_rdy;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  stream_burst_tx #(.DW(DW), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd_start (cmd_start),
    .cmd_len   (cmd_len),
    .cmd_step  (cmd_step),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one descriptor and follow the whole burst, checking every beat
  // against start + i*step (plus the checksum word when enabled).
  // rdy_mode 0: out_rdy always high; 1: pattern 1,0,0,1,0,0,...
  // keep_vld leaves cmd_vld high after acceptance.
  task automatic burst(input string tag, input logic [15:0] start, input logic [7:0] len,
                       input logic [15:0] step, input int rdy_mode, input bit keep_vld);
    logic [15:0] expd;
    logic [15:0] sum;
    logic [15:0] prev_data;
    logic        prev_last;
    bit          stalled;
    bit          is_last;
    int          nbeats;
    int          idx;
    int          cyc;
    check($sformatf("%s/cmd_rdy_idle", tag), cmd_rdy, 1);
    cmd_vld   = 1'b1;
    cmd_start = start;
    cmd_len   = len;
    cmd_step  = step;
    @(negedge clk);
    if (!keep_vld) cmd_vld = 1'b0;
    nbeats = int'(len) + 1;
`ifdef STREAM_TX_CSUM_EN
    nbeats = nbeats + 1;
`endif
    idx = 0; cyc = 0; sum = '0; stalled = 0; prev_data = '0; prev_last = 1'b0;
    while (idx < nbeats && cyc < 2000) begin
      out_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      check($sformatf("%s/vld c%0d", tag, cyc), out_vld, 1);
      check($sformatf("%s/cmd_rdy_busy c%0d", tag, cyc), cmd_rdy, 0);
      if (stalled) begin
        check($sformatf("%s/stall_data c%0d", tag, cyc), out_data, prev_data);
        check($sformatf("%s/stall_last c%0d", tag, cyc), out_last, prev_last);
      end
      if (out_rdy) begin
        if (idx <= int'(len)) begin
          expd = 16'(start + 16'(idx) * step);
          sum  = 16'(sum + expd);
        end else begin
          expd = sum;
        end
        is_last = (idx == nbeats - 1);
        check($sformatf("%s/data b%0d", tag, idx), out_data, expd);
        check($sformatf("%s/last b%0d", tag, idx), out_last, is_last);
        check($sformatf("%s/busy b%0d", tag, idx), busy, 1);
        idx++;
        stalled = 0;
      end else begin
        stalled = 1;
      end
      prev_data = out_data;
      prev_last = out_last;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s/timeout", tag), 32'(idx), 32'(nbeats));
    check($sformatf("%s/end_vld", tag), out_vld, 0);
    check($sformatf("%s/end_last", tag), out_last, 0);
    check($sformatf("%s/end_busy", tag), busy, 0);
    check($sformatf("%s/end_cmd_rdy", tag), cmd_rdy, 1);
  endtask

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_start = '0; cmd_len = '0; cmd_step = '0; out_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset/vld", out_vld, 0);
    check("reset/data", out_data, 0);
    check("reset/last", out_last, 0);
    check("reset/busy", busy, 0);
    check("reset/cmd_rdy", cmd_rdy, 1);
    rst = 1'b0;
    @(negedge clk);

    burst("basic", 16'h0010, 8'd3, 16'h0002, 0, 0);
    burst("stall", 16'h0010, 8'd3, 16'h0002, 1, 0);
    burst("wrap", 16'hFFFE, 8'd2, 16'h0001, 0, 0);
    burst("len0", 16'hABCD, 8'd0, 16'h1111, 0, 0);
    burst("step0", 16'h5A5A, 8'd4, 16'h0000, 1, 0);

    // Back-to-back: cmd_vld held high; second accepted after one idle cycle.
    burst("b2b_a", 16'h0100, 8'd2, 16'h0010, 0, 1);
    burst("b2b_b", 16'h0200, 8'd1, 16'h0003, 0, 0);

    burst("maxlen", 16'h0000, 8'd255, 16'h0101, 0, 0);

    // Reset mid-burst after two of four beats, with out_rdy low.
    cmd_vld = 1'b1; cmd_start = 16'h0100; cmd_len = 8'd3; cmd_step = 16'h0001; out_rdy = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    check("mid/beat0", out_data, 16'h0100);
    @(negedge clk);
    check("mid/beat1", out_data, 16'h0101);
    @(negedge clk);
    out_rdy = 1'b0;
    check("mid/held_data", out_data, 16'h0102);
    check("mid/held_vld", out_vld, 1);
    #2 rst = 1'b1;
    #1;
    check("mid/rst_vld", out_vld, 0);
    check("mid/rst_last", out_last, 0);
    check("mid/rst_busy", busy, 0);
    check("mid/rst_data", out_data, 0);
    check("mid/rst_cmd_rdy", cmd_rdy, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    burst("after_rst", 16'h0700, 8'd2, 16'h0005, 0, 0);

    burst("csum_vec", 16'h0001, 8'd2, 16'h0001, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_burst_tx.md
Name: stream_burst_tx

Overview:
- Valid/ready stream transmitter. It accepts a burst descriptor (start word, length, step) on a command handshake.
- It emits the described sequence of 16-bit words on a valid/ready output stream that obeys the same handshake rules as our pipe stages.
- Sits upstream of pipe-stage chains as the traffic source for datapath bring-up and for DMA-style fills.

Parameters:
DW, 16, data word width of cmd_start, cmd_step, out_data
LEN_W, 8, width of cmd_len; a burst carries at most 2^LEN_W words

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_vld  input  1  descriptor valid
cmd_rdy  output  1  descriptor accepted when cmd_vld && cmd_rdy
cmd_start  input  DW  first data word of the burst
cmd_len  input  LEN_W  word count minus one (0 = 1 word)
cmd_step  input  DW  increment added between consecutive words
out_vld  output  1  output word valid
out_rdy  input  1  downstream ready
out_data  output  DW  output word
out_last  output  1  marks final beat of the burst
busy  output  1  high whenever not IDLE

Behaviour:
- Reset: all state and outputs clear asynchronously on rst high: state=IDLE, out_vld=0, out_data=0, out_last=0, busy=0, counters=0. Any burst in progress is discarded, with no partial completion.
- Beat definition: a beat transfers on a rising edge where out_vld && out_rdy.
- FSM states: IDLE, SEND, plus CSUM when the optional feature is enabled.
- IDLE:
  - cmd_rdy=1 (combinational from state). All other outputs low.
  - On cmd_vld && cmd_rdy: latch cmd_start/cmd_len/cmd_step, set remaining=cmd_len, out_data=cmd_start, out_vld=1, out_last=(cmd_len==0), and go to SEND. First word is visible the cycle after command acceptance.
- SEND:
  - cmd_rdy=0. Command inputs are ignored.
  - On a beat with remaining!=0: out_data <= out_data + step (mod 2^DW, wraps silently), remaining <= remaining-1, out_last <= (remaining==1).
  - On a beat with remaining==0: the burst is complete. Go to IDLE with out_vld=0 and out_last=0.
- Handshake rules:
  - Once out_vld is high, it stays high, and out_data and out_last stay stable, until the beat completes.
  - out_vld never depends combinationally on out_rdy.
  - out_rdy held high gives one word per cycle.
  - Backpressure of any length stalls with no loss or duplication.
- Burst spacing: cmd_rdy is only high in IDLE, so consecutive bursts are separated by exactly one idle cycle after the last beat.
- cmd_len=2^LEN_W-1 emits 2^LEN_W words. remaining never underflows.
- cmd_step=0 repeats cmd_start for every word.

Optional Feature:
- Macro: STREAM_TX_CSUM_EN.
- Defined:
  - A running 16-bit sum (mod 2^DW) accumulates every data word beat.
  - After the final data beat, the FSM enters CSUM and emits one extra word equal to the sum, with out_last=1. The final data word then has out_last=0.
  - The CSUM beat obeys the same handshake rules. The sum clears on command accept and on reset.
- Undefined: no CSUM state and no accumulator. out_last is asserted on the final data word.

Decomposition:
- Shared package stream_pkg: state enum (IDLE, SEND, CSUM) and default DW/LEN_W constants, reused by future stream_burst_rx/checker blocks.
- Single flat module. No sub-module is needed; the FSM, counter and accumulator are small.

Test Plan:
- Reset then cmd{start=0x0010,len=3,step=0x0002}, out_rdy=1 -> out_data 0x0010,0x0012,0x0014,0x0016 on consecutive cycles; last on 0x0016; cmd_rdy high again the cycle after.
- Same command, out_rdy toggling 1,0,0,1,... -> identical sequence; out_vld/out_data stable through every stall; no duplicates.
- cmd{start=0xFFFE,len=2,step=0x0001} -> 0xFFFE,0xFFFF,0x0000 (wrap); cmd{len=0} -> single word with out_last=1.
- Two back-to-back commands with cmd_vld held high -> second accepted exactly one cycle after the first burst's last beat; cmd_rdy=0 throughout SEND.
- rst asserted mid-burst (after 2 of 4 beats, out_rdy=0) -> out_vld, out_last, busy drop immediately; the next command restarts cleanly from its own cmd_start.
- STREAM_TX_CSUM_EN defined, cmd{start=0x0001,len=2,step=0x0001} -> 0x0001,0x0002,0x0003 then checksum 0x0006 with out_last=1 only on the checksum beat.
